// File: rtl/bj_pkg.sv
// rtl/bj_pkg.sv - shared deck constants, draw FSM states and card rank-to-value mapping
package bj_pkg;

    localparam int CARDS_PER_DECK = 52;
    localparam int RANKS          = 13;
    localparam logic [3:0] ACE    = 4'd1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PICK,
        S_PROBE,
        S_DELIVER,
        S_SHUFFLE
    } state_t;

    // Slot n holds rank n%13: ace first, then 2..10, then three ten-valued faces.
    function automatic logic [3:0] index_to_value(input logic [5:0] idx);
        int r;
        r = int'(idx) % RANKS;
        if (r == 0) return ACE;
        return (r < 10) ? 4'(r + 1) : 4'd10;
    endfunction

endpackage

// File: rtl/card_lfsr.sv
// rtl/card_lfsr.sv - 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1, reloadable seed
module card_lfsr (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] seed,
    output logic [7:0] q
);

    always_ff @(posedge clk) begin
        if (rst || load) begin
            q <= seed;
        end else begin
            q <= {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
        end
    end

endmodule

// File: rtl/card_deck_arbiter.sv
// rtl/card_deck_arbiter.sv - 52-card shoe, round-robin player/dealer draws; BJ_FIXED_DECK_EN deals in order
module card_deck_arbiter
    import bj_pkg::*;
#(
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       shuffle,
    input  logic       req_player,
    input  logic       req_dealer,
    output logic       ack_player,
    output logic       ack_dealer,
    output logic [3:0] card_value,
    output logic [5:0] card_index,
    output logic       deck_empty,
    output logic [5:0] cards_remaining,
    output logic       busy,
    output logic       shuffle_done
);

    state_t                    state;
    logic [CARDS_PER_DECK-1:0] used;
    logic [5:0]                idx;
    logic                      gnt_dealer;
    logic                      last_dealer;
    logic                      shuffle_pending;

    function automatic logic [5:0] wrap_inc(input logic [5:0] i);
        return (i == 6'(CARDS_PER_DECK - 1)) ? 6'd0 : i + 6'd1;
    endfunction

`ifdef BJ_FIXED_DECK_EN
    logic [5:0] deal_ptr;
`else
    logic [7:0] lfsr_q;
    logic [5:0] pick_idx;
    logic       lfsr_unused;

    card_lfsr u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .load (shuffle),
        .seed (LFSR_SEED),
        .q    (lfsr_q)
    );

    assign pick_idx    = (lfsr_q[5:0] >= 6'(CARDS_PER_DECK)) ? lfsr_q[5:0] - 6'(CARDS_PER_DECK)
                                                             : lfsr_q[5:0];
    assign lfsr_unused = ^lfsr_q[7:6];
`endif

    // A requester whose ack is showing this cycle has just been served; ignore its held request.
    logic req_p, req_d, pick_dealer;
    assign req_p       = req_player & ~ack_player;
    assign req_d       = req_dealer & ~ack_dealer;
    assign pick_dealer = req_d & (~req_p | ~last_dealer);

    assign busy = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= S_IDLE;
            used            <= '0;
            idx             <= '0;
            gnt_dealer      <= 1'b0;
            last_dealer     <= 1'b1;
            shuffle_pending <= 1'b0;
            ack_player      <= 1'b0;
            ack_dealer      <= 1'b0;
            card_value      <= '0;
            card_index      <= '0;
            deck_empty      <= 1'b0;
            cards_remaining <= 6'(CARDS_PER_DECK);
            shuffle_done    <= 1'b0;
`ifdef BJ_FIXED_DECK_EN
            deal_ptr        <= '0;
`endif
        end else begin
            ack_player   <= 1'b0;
            ack_dealer   <= 1'b0;
            shuffle_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (shuffle || shuffle_pending) begin
                        shuffle_pending <= 1'b0;
                        state           <= S_SHUFFLE;
                    end else if (req_p || req_d) begin
                        if (cards_remaining == 6'd0) begin
                            ack_player <= ~pick_dealer;
                            ack_dealer <= pick_dealer;
                            deck_empty <= 1'b1;
                            card_value <= '0;
                        end else begin
                            gnt_dealer <= pick_dealer;
                            state      <= S_PICK;
                        end
                    end
                end
                S_PICK: begin
`ifdef BJ_FIXED_DECK_EN
                    idx      <= deal_ptr;
                    deal_ptr <= deal_ptr + 6'd1;
                    state    <= S_DELIVER;
`else
                    if (!used[pick_idx]) begin
                        idx   <= pick_idx;
                        state <= S_DELIVER;
                    end else begin
                        idx   <= wrap_inc(pick_idx);
                        state <= S_PROBE;
                    end
`endif
                end
                S_PROBE: begin
                    if (!used[idx]) state <= S_DELIVER;
                    else            idx   <= wrap_inc(idx);
                end
                S_DELIVER: begin
                    used[idx]       <= 1'b1;
                    cards_remaining <= cards_remaining - 6'd1;
                    card_index      <= idx;
                    card_value      <= index_to_value(idx);
                    deck_empty      <= 1'b0;
                    ack_player      <= ~gnt_dealer;
                    ack_dealer      <= gnt_dealer;
                    last_dealer     <= gnt_dealer;
                    state           <= S_IDLE;
                end
                S_SHUFFLE: begin
                    used            <= '0;
                    cards_remaining <= 6'(CARDS_PER_DECK);
                    shuffle_done    <= 1'b1;
                    state           <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
            // A shuffle arriving mid-draw waits for the draw to finish.
            if (shuffle && state != S_IDLE) shuffle_pending <= 1'b1;
`ifdef BJ_FIXED_DECK_EN
            if (shuffle) deal_ptr <= '0;
`endif
        end
    end

endmodule

// File: tb/tb_card_deck_arbiter.sv
// tb/tb_card_deck_arbiter.sv - directed bench for card_deck_arbiter (LFSR build or BJ_FIXED_DECK_EN build)
module tb_card_deck_arbiter;

    logic       clk = 1'b0;
    logic       rst, shuffle, req_player, req_dealer;
    logic       ack_player, ack_dealer, deck_empty, busy, shuffle_done;
    logic [3:0] card_value;
    logic [5:0] card_index, cards_remaining;

    int checks   = 0;
    int failures = 0;

    card_deck_arbiter dut (
        .clk             (clk),
        .rst             (rst),
        .shuffle         (shuffle),
        .req_player      (req_player),
        .req_dealer      (req_dealer),
        .ack_player      (ack_player),
        .ack_dealer      (ack_dealer),
        .card_value      (card_value),
        .card_index      (card_index),
        .deck_empty      (deck_empty),
        .cards_remaining (cards_remaining),
        .busy            (busy),
        .shuffle_done    (shuffle_done)
    );

    always #5 clk = ~clk;

`ifdef BJ_FIXED_DECK_EN
    localparam logic [5:0] EXP_I0 = 6'd0,  EXP_I1 = 6'd1,  EXP_I2 = 6'd2;
    localparam logic [3:0] EXP_V0 = 4'd1,  EXP_V1 = 4'd2,  EXP_V2 = 4'd3;
`else
    localparam logic [5:0] EXP_I0 = 6'd10, EXP_I1 = 6'd20, EXP_I2 = 6'd39;
    localparam logic [3:0] EXP_V0 = 4'd10, EXP_V1 = 4'd8,  EXP_V2 = 4'd1;
`endif

    function automatic logic [3:0] exp_value(input int i);
        int r;
        r = i % 13;
        return (r < 10) ? 4'(r + 1) : 4'd10;
    endfunction

    // Ends on a negedge with rst just released; the next posedge is the first active cycle.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; shuffle = 1'b0; req_player = 1'b0; req_dealer = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic draw(input bit dealer, output int lat, output bit ok, output bit who);
        @(negedge clk);
        if (dealer) req_dealer = 1'b1; else req_player = 1'b1;
        ok = 1'b0; lat = 0; who = 1'b0;
        for (int i = 1; i <= 60 && !ok; i++) begin
            @(negedge clk);
            if (ack_player || ack_dealer) begin
                ok = 1'b1; lat = i; who = ack_dealer;
            end
        end
        req_player = 1'b0; req_dealer = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (cards_remaining !== 6'd52) begin
            failures++; $display("FAIL reset_remaining got=%0d exp=52", cards_remaining);
        end
        checks++;
        if ({ack_player, ack_dealer, busy, deck_empty, shuffle_done} !== 5'b0) begin
            failures++; $display("FAIL reset_flags got=%b exp=00000",
                                 {ack_player, ack_dealer, busy, deck_empty, shuffle_done});
        end
        checks++;
        if ({card_value, card_index} !== 10'd0) begin
            failures++; $display("FAIL reset_card got=%0d/%0d exp=0/0", card_value, card_index);
        end
    endtask

    task automatic test_first_draw();
        logic early;
        do_reset();
        req_player = 1'b1;
        early = 1'b0;
        repeat (2) begin
            @(negedge clk);
            early = early | ack_player | ack_dealer;
        end
        @(negedge clk);
        req_player = 1'b0;
        checks++;
        if (early !== 1'b0 || ack_player !== 1'b1 || ack_dealer !== 1'b0) begin
            failures++; $display("FAIL first_ack_timing got=early%b/p%b/d%b exp=early0/p1/d0",
                                 early, ack_player, ack_dealer);
        end
        checks++;
        if (card_index !== EXP_I0 || card_value !== EXP_V0) begin
            failures++; $display("FAIL first_card got=%0d/%0d exp=%0d/%0d",
                                 card_index, card_value, EXP_I0, EXP_V0);
        end
        checks++;
        if (cards_remaining !== 6'd51) begin
            failures++; $display("FAIL first_remaining got=%0d exp=51", cards_remaining);
        end
    endtask

    task automatic test_alternate();
        logic [5:0] gi [3];
        logic [3:0] gv [3];
        logic       gw [3];
        logic       both;
        int         n;
        logic [5:0] ei [3];
        logic [3:0] ev [3];
        ei[0] = EXP_I0; ei[1] = EXP_I1; ei[2] = EXP_I2;
        ev[0] = EXP_V0; ev[1] = EXP_V1; ev[2] = EXP_V2;
        do_reset();
        req_player = 1'b1; req_dealer = 1'b1;
        n = 0; both = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (ack_player && ack_dealer) both = 1'b1;
            if ((ack_player || ack_dealer) && n < 3) begin
                gi[n] = card_index; gv[n] = card_value; gw[n] = ack_dealer; n++;
            end
        end
        req_player = 1'b0; req_dealer = 1'b0;
        checks++;
        if (both !== 1'b0 || n != 3) begin
            failures++; $display("FAIL alt_ack_count got=both%b/n%0d exp=both0/n3", both, n);
        end
        for (int k = 0; k < n; k++) begin
            checks++;
            if (gw[k] !== 1'(k % 2) || gi[k] !== ei[k] || gv[k] !== ev[k]) begin
                failures++; $display("FAIL alt_draw%0d got=who%0d/%0d/%0d exp=who%0d/%0d/%0d",
                                     k, gw[k], gi[k], gv[k], k % 2, ei[k], ev[k]);
            end
        end
    endtask

    task automatic test_full_deck();
        logic [51:0] seen;
        int  lat;
        bit  ok, who;
        do_reset();
        seen = '0;
        for (int i = 0; i < 52; i++) begin
            draw(1'b0, lat, ok, who);
            checks++;
            if (!ok || who !== 1'b0 || lat < 3 || lat > 54) begin
                failures++; $display("FAIL deck_ack%0d got=ok%0d/who%0d/lat%0d exp=ok1/who0/lat3..54",
                                     i, ok, who, lat);
            end
            checks++;
            if (card_index > 6'd51 || seen[card_index % 52]) begin
                failures++; $display("FAIL deck_unique%0d got=%0d exp=unused slot", i, card_index);
            end else begin
                seen[card_index] = 1'b1;
            end
            checks++;
            if (card_value !== exp_value(int'(card_index)) || deck_empty !== 1'b0) begin
                failures++; $display("FAIL deck_value%0d got=%0d exp=%0d", i, card_value,
                                     exp_value(int'(card_index)));
            end
            checks++;
            if (cards_remaining !== 6'(51 - i)) begin
                failures++; $display("FAIL deck_remaining%0d got=%0d exp=%0d", i, cards_remaining, 51 - i);
            end
`ifdef BJ_FIXED_DECK_EN
            checks++;
            if (card_index !== 6'(i) || lat != 3) begin
                failures++; $display("FAIL fixed_order%0d got=%0d/lat%0d exp=%0d/lat3", i, card_index, lat, i);
            end
`endif
        end
        draw(1'b1, lat, ok, who);
        checks++;
        if (!ok || lat != 1 || who !== 1'b1 || deck_empty !== 1'b1 || card_value !== 4'd0) begin
            failures++; $display("FAIL empty_ack got=ok%0d/lat%0d/who%0d/empty%0d/val%0d exp=1/1/1/1/0",
                                 ok, lat, who, deck_empty, card_value);
        end
        checks++;
        if (cards_remaining !== 6'd0) begin
            failures++; $display("FAIL empty_remaining got=%0d exp=0", cards_remaining);
        end
        @(negedge clk); shuffle = 1'b1;
        @(negedge clk); shuffle = 1'b0;
        checks++;
        if (shuffle_done !== 1'b0 || busy !== 1'b1) begin
            failures++; $display("FAIL shuffle_state got=done%0d/busy%0d exp=0/1", shuffle_done, busy);
        end
        @(negedge clk);
        checks++;
        if (shuffle_done !== 1'b1 || cards_remaining !== 6'd52) begin
            failures++; $display("FAIL shuffle_done got=%0d/%0d exp=1/52", shuffle_done, cards_remaining);
        end
        draw(1'b0, lat, ok, who);
        checks++;
        if (!ok || cards_remaining !== 6'd51) begin
            failures++; $display("FAIL post_shuffle got=ok%0d/%0d exp=ok1/51", ok, cards_remaining);
        end
`ifdef BJ_FIXED_DECK_EN
        checks++;
        if (card_index !== 6'd0 || card_value !== 4'd1) begin
            failures++; $display("FAIL post_shuffle_card got=%0d/%0d exp=0/1", card_index, card_value);
        end
`endif
    endtask

`ifndef BJ_FIXED_DECK_EN
    // Draw A picks slot 29; draw B's pick also lands on 29, so B is left probing toward slot 30.
    task automatic drive_to_probe(output logic a_ack, output logic [5:0] a_idx, output logic [3:0] a_val);
        do_reset();
        repeat (8) @(negedge clk);
        req_player = 1'b1;
        repeat (3) @(negedge clk);
        a_ack = ack_player; a_idx = card_index; a_val = card_value;
        req_player = 1'b0;
        @(negedge clk);
        req_player = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_shuffle_during_probe();
        logic       a_ack;
        logic [5:0] a_idx;
        logic [3:0] a_val;
        drive_to_probe(a_ack, a_idx, a_val);
        checks++;
        if (a_ack !== 1'b1 || a_idx !== 6'd29 || a_val !== 4'd4) begin
            failures++; $display("FAIL probe_first got=ack%0d/%0d/%0d exp=ack1/29/4", a_ack, a_idx, a_val);
        end
        checks++;
        if (busy !== 1'b1 || ack_player !== 1'b0) begin
            failures++; $display("FAIL probe_busy got=busy%0d/ack%0d exp=1/0", busy, ack_player);
        end
        shuffle = 1'b1;
        @(negedge clk);
        shuffle = 1'b0;
        checks++;
        if (ack_player !== 1'b0 || shuffle_done !== 1'b0) begin
            failures++; $display("FAIL probe_deliver got=ack%0d/done%0d exp=0/0", ack_player, shuffle_done);
        end
        @(negedge clk);
        req_player = 1'b0;
        checks++;
        if (ack_player !== 1'b1 || card_index !== 6'd30 || card_value !== 4'd5 ||
            cards_remaining !== 6'd50 || shuffle_done !== 1'b0) begin
            failures++; $display("FAIL probe_ack got=ack%0d/%0d/%0d/rem%0d/done%0d exp=ack1/30/5/rem50/done0",
                                 ack_player, card_index, card_value, cards_remaining, shuffle_done);
        end
        @(negedge clk);
        checks++;
        if (shuffle_done !== 1'b0 || busy !== 1'b1) begin
            failures++; $display("FAIL pending_shuffle got=done%0d/busy%0d exp=0/1", shuffle_done, busy);
        end
        @(negedge clk);
        checks++;
        if (shuffle_done !== 1'b1 || cards_remaining !== 6'd52) begin
            failures++; $display("FAIL pending_done got=%0d/%0d exp=1/52", shuffle_done, cards_remaining);
        end
    endtask

    task automatic test_reset_during_probe();
        logic       a_ack, any_ack;
        logic [5:0] a_idx;
        logic [3:0] a_val;
        drive_to_probe(a_ack, a_idx, a_val);
        rst = 1'b1; req_player = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        any_ack = 1'b0;
        repeat (4) begin
            @(negedge clk);
            any_ack = any_ack | ack_player | ack_dealer;
        end
        checks++;
        if (any_ack !== 1'b0 || cards_remaining !== 6'd52 || busy !== 1'b0) begin
            failures++; $display("FAIL rst_probe got=ack%0d/rem%0d/busy%0d exp=0/52/0",
                                 any_ack, cards_remaining, busy);
        end
    endtask
`endif

    initial begin
        rst = 1'b1; shuffle = 1'b0; req_player = 1'b0; req_dealer = 1'b0;
        test_reset();
        test_first_draw();
        test_alternate();
        test_full_deck();
`ifndef BJ_FIXED_DECK_EN
        test_shuffle_during_probe();
        test_reset_during_probe();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
